// File: rtl/easy_fifo_axis_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide word
// ahead of the sync FIFO write port, in the FIFO write clock domain.
// Optional input skid register: define EASY_FIFO_UPSIZER_SKID_EN.
// Ports:
//   rst, wr_clk_int           async active-high reset, write clock
//   s_axis_tdata/tvalid/tlast narrow input beat
//   s_axis_tready             input beat accepted when tvalid is high
//   m_axis_tdata/tkeep/tlast  packed word, lane 0 in the low bits
//   m_axis_tvalid/tready      packed word handshake (tready = FIFO not-full)
module easy_fifo_axis_upsizer #(
  parameter int S_DWIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                         rst,
  input  logic                         wr_clk_int,
  input  logic [S_DWIDTH-1:0]          s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [S_DWIDTH*RATIO-1:0]    m_axis_tdata,
  output logic [RATIO-1:0]             m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready
);

  localparam int M_DWIDTH = S_DWIDTH * RATIO;
  localparam int IDXW     = (RATIO > 1) ? $clog2(RATIO) : 1;

  logic [IDXW-1:0]     idx_q, idx_d;
  logic [M_DWIDTH-1:0] acc_q, acc_d;
  logic [M_DWIDTH-1:0] mdata_q, mdata_d;
  logic [RATIO-1:0]    mkeep_q, mkeep_d;
  logic                mlast_q, mlast_d;
  logic                mvalid_q, mvalid_d;

  // Beat presented to the packer (input port or skid entry)
  logic                in_vld;
  logic [S_DWIDTH-1:0] in_data;
  logic                in_last;

  logic last_lane;
  logic complete;
  logic out_free;
  logic take;

  assign last_lane = (idx_q == IDXW'(RATIO - 1));
  assign complete  = last_lane | in_last;
  // Output register can take a new word this edge
  assign out_free  = ~mvalid_q | m_axis_tready;
  // Non-completing beats never need the output register
  assign take      = in_vld & (~complete | out_free);

`ifdef EASY_FIFO_UPSIZER_SKID_EN
  logic                skid_vld_q, skid_vld_d;
  logic [S_DWIDTH-1:0] skid_data_q, skid_data_d;
  logic                skid_last_q, skid_last_d;

  // A held skid entry always goes first; the port is closed meanwhile
  assign in_vld        = skid_vld_q | s_axis_tvalid;
  assign in_data       = skid_vld_q ? skid_data_q : s_axis_tdata;
  assign in_last       = skid_vld_q ? skid_last_q : s_axis_tlast;
  assign s_axis_tready = ~skid_vld_q;

  always_comb begin
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    if (skid_vld_q) begin
      if (take) begin
        skid_vld_d = 1'b0;
      end
    end else if (s_axis_tvalid && !take) begin
      // Completing beat blocked by a stalled word: park it
      skid_vld_d  = 1'b1;
      skid_data_d = s_axis_tdata;
      skid_last_d = s_axis_tlast;
    end
  end

  always_ff @(posedge wr_clk_int or posedge rst) begin
    if (rst) begin
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
    end
  end
`else
  assign in_vld        = s_axis_tvalid;
  assign in_data       = s_axis_tdata;
  assign in_last       = s_axis_tlast;
  assign s_axis_tready = ~complete | out_free;
`endif

  always_comb begin
    idx_d    = idx_q;
    acc_d    = acc_q;
    mdata_d  = mdata_q;
    mkeep_d  = mkeep_q;
    mlast_d  = mlast_q;
    mvalid_d = mvalid_q;
    if (mvalid_q && m_axis_tready) begin
      mvalid_d = 1'b0;
    end
    if (take) begin
      for (int i = 0; i < RATIO; i++) begin
        if (IDXW'(i) == idx_q) begin
          acc_d[i*S_DWIDTH +: S_DWIDTH] = in_data;
        end
      end
      if (complete) begin
        // Lanes below idx from the accumulator, lane idx from the
        // current beat, lanes above idx zeroed
        for (int i = 0; i < RATIO; i++) begin
          if (i < int'(idx_q)) begin
            mdata_d[i*S_DWIDTH +: S_DWIDTH] = acc_q[i*S_DWIDTH +: S_DWIDTH];
            mkeep_d[i] = 1'b1;
          end else if (i == int'(idx_q)) begin
            mdata_d[i*S_DWIDTH +: S_DWIDTH] = in_data;
            mkeep_d[i] = 1'b1;
          end else begin
            mdata_d[i*S_DWIDTH +: S_DWIDTH] = '0;
            mkeep_d[i] = 1'b0;
          end
        end
        mlast_d  = in_last;
        mvalid_d = 1'b1;
        idx_d    = '0;
      end else begin
        idx_d = idx_q + IDXW'(1);
      end
    end
  end

  always_ff @(posedge wr_clk_int or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      acc_q    <= '0;
      mdata_q  <= '0;
      mkeep_q  <= '0;
      mlast_q  <= 1'b0;
      mvalid_q <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      mdata_q  <= mdata_d;
      mkeep_q  <= mkeep_d;
      mlast_q  <= mlast_d;
      mvalid_q <= mvalid_d;
    end
  end

  assign m_axis_tdata  = mdata_q;
  assign m_axis_tkeep  = mkeep_q;
  assign m_axis_tlast  = mlast_q;
  assign m_axis_tvalid = mvalid_q;

endmodule
